// File: rtl/axi_stream_header_arbiter.sv
// rtl/axi_stream_header_arbiter.sv - round-robin header arbiter feeding a stream header inserter
module axi_stream_header_arbiter #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
    parameter int CNT_WD       = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_hdr0,
    input  logic [DATA_WD-1:0]      data_hdr0,
    input  logic [DATA_BYTE_WD-1:0] keep_hdr0,
    input  logic [BYTE_CNT_WD-1:0]  byte_cnt_hdr0,
    output logic                    ready_hdr0,
    input  logic                    valid_hdr1,
    input  logic [DATA_WD-1:0]      data_hdr1,
    input  logic [DATA_BYTE_WD-1:0] keep_hdr1,
    input  logic [BYTE_CNT_WD-1:0]  byte_cnt_hdr1,
    output logic                    ready_hdr1,
    output logic                    valid_insert,
    output logic [DATA_WD-1:0]      data_insert,
    output logic [DATA_BYTE_WD-1:0] keep_insert,
    output logic [BYTE_CNT_WD-1:0]  byte_insert_cnt,
    input  logic                    ready_insert,
    input  logic                    mon_valid,
    input  logic                    mon_ready,
    input  logic                    mon_last,
    output logic                    grant_id,
    output logic                    busy,
    output logic [CNT_WD-1:0]       pkt_cnt0,
    output logic [CNT_WD-1:0]       pkt_cnt1
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        OFFER     = 2'd1,
        WAIT_LAST = 2'd2
    } state_t;

    localparam logic [CNT_WD-1:0] CNT_ONE = {{(CNT_WD-1){1'b0}}, 1'b1};

    state_t                  state_q, state_d;
    logic [DATA_WD-1:0]      data_q, data_d;
    logic [DATA_BYTE_WD-1:0] keep_q, keep_d;
    logic [BYTE_CNT_WD-1:0]  bcnt_q, bcnt_d;
    logic                    grant_q, grant_d;
    logic                    last_grant_q, last_grant_d;
    logic [CNT_WD-1:0]       cnt0_q, cnt0_d;
    logic [CNT_WD-1:0]       cnt1_q, cnt1_d;
    logic                    winner;
    logic                    last_beat;

    // On a tie the requester that did not finish the previous packet wins.
    assign winner    = (valid_hdr0 & valid_hdr1) ? ~last_grant_q : valid_hdr1;
    assign last_beat = mon_valid & mon_ready & mon_last;

    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        keep_d       = keep_q;
        bcnt_d       = bcnt_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt0_d       = cnt0_q;
        cnt1_d       = cnt1_q;
        ready_hdr0   = 1'b0;
        ready_hdr1   = 1'b0;
        case (state_q)
            IDLE: begin
                if ((valid_hdr0 | valid_hdr1) && !rst) begin
                    ready_hdr0 = ~winner;
                    ready_hdr1 = winner;
                    data_d     = winner ? data_hdr1 : data_hdr0;
                    keep_d     = winner ? keep_hdr1 : keep_hdr0;
                    bcnt_d     = winner ? byte_cnt_hdr1 : byte_cnt_hdr0;
                    grant_d    = winner;
                    state_d    = OFFER;
                end
            end
            OFFER: begin
                if (ready_insert) begin
                    state_d = WAIT_LAST;
                end
            end
            WAIT_LAST: begin
                if (last_beat) begin
                    last_grant_d = grant_q;
                    if (grant_q) begin
                        cnt1_d = cnt1_q + CNT_ONE;
                    end else begin
                        cnt0_d = cnt0_q + CNT_ONE;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            data_q       <= '0;
            keep_q       <= '0;
            bcnt_q       <= '0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            keep_q       <= keep_d;
            bcnt_q       <= bcnt_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
        end
    end

    assign valid_insert    = (state_q == OFFER);
    assign busy            = (state_q != IDLE);
    assign data_insert     = data_q;
    assign keep_insert     = keep_q;
    assign byte_insert_cnt = bcnt_q;
    assign grant_id        = grant_q;
    assign pkt_cnt0        = cnt0_q;
    assign pkt_cnt1        = cnt1_q;

endmodule

// File: tb/tb_axi_stream_header_arbiter.sv
// tb/tb_axi_stream_header_arbiter.sv - directed and random checks against a packet-level reference model
module tb_axi_stream_header_arbiter;

    localparam int DW = 32;
    localparam int BW = 4;
    localparam int CW = 2;
    localparam int NW = 8;

    localparam int FREE = 0;
    localparam int HDR  = 1;
    localparam int PKT  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          valid_hdr0, valid_hdr1;
    logic [DW-1:0] data_hdr0, data_hdr1;
    logic [BW-1:0] keep_hdr0, keep_hdr1;
    logic [CW-1:0] byte_cnt_hdr0, byte_cnt_hdr1;
    logic          ready_hdr0, ready_hdr1;
    logic          valid_insert;
    logic [DW-1:0] data_insert;
    logic [BW-1:0] keep_insert;
    logic [CW-1:0] byte_insert_cnt;
    logic          ready_insert;
    logic          mon_valid, mon_ready, mon_last;
    logic          grant_id;
    logic          busy;
    logic [NW-1:0] pkt_cnt0, pkt_cnt1;

    axi_stream_header_arbiter #(
        .DATA_WD(DW), .DATA_BYTE_WD(BW), .BYTE_CNT_WD(CW), .CNT_WD(NW)
    ) dut (
        .clk(clk), .rst(rst),
        .valid_hdr0(valid_hdr0), .data_hdr0(data_hdr0), .keep_hdr0(keep_hdr0),
        .byte_cnt_hdr0(byte_cnt_hdr0), .ready_hdr0(ready_hdr0),
        .valid_hdr1(valid_hdr1), .data_hdr1(data_hdr1), .keep_hdr1(keep_hdr1),
        .byte_cnt_hdr1(byte_cnt_hdr1), .ready_hdr1(ready_hdr1),
        .valid_insert(valid_insert), .data_insert(data_insert), .keep_insert(keep_insert),
        .byte_insert_cnt(byte_insert_cnt), .ready_insert(ready_insert),
        .mon_valid(mon_valid), .mon_ready(mon_ready), .mon_last(mon_last),
        .grant_id(grant_id), .busy(busy), .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
    );

    int checks = 0;
    int failures = 0;

    int            m_stage;
    int            m_owner;
    int            m_last;
    int            m_cnt[2];
    logic [DW-1:0] m_data;
    logic [BW-1:0] m_keep;
    logic [CW-1:0] m_bcnt;
    int            obs_grants[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick();
        if (valid_hdr0 && valid_hdr1) return (m_last == 0) ? 1 : 0;
        if (valid_hdr0) return 0;
        if (valid_hdr1) return 1;
        return -1;
    endfunction

    // One clock: compare every output with the model mid-cycle, then advance the model.
    task automatic cycle();
        int   w;
        logic e0, e1;
        @(negedge clk);
        w  = pick();
        e0 = !rst && (m_stage == FREE) && (w == 0);
        e1 = !rst && (m_stage == FREE) && (w == 1);
        chk("ready_hdr0", 32'(ready_hdr0), 32'(e0));
        chk("ready_hdr1", 32'(ready_hdr1), 32'(e1));
        chk("valid_insert", 32'(valid_insert), 32'(m_stage == HDR));
        chk("busy", 32'(busy), 32'(m_stage != FREE));
        chk("data_insert", data_insert, m_data);
        chk("keep_insert", 32'(keep_insert), 32'(m_keep));
        chk("byte_insert_cnt", 32'(byte_insert_cnt), 32'(m_bcnt));
        chk("grant_id", 32'(grant_id), 32'(m_owner));
        chk("pkt_cnt0", 32'(pkt_cnt0), 32'(m_cnt[0]));
        chk("pkt_cnt1", 32'(pkt_cnt1), 32'(m_cnt[1]));
        if (ready_hdr0 || ready_hdr1) obs_grants.push_back(ready_hdr1 ? 1 : 0);
        if (rst) begin
            m_stage = FREE; m_owner = 0; m_last = 1;
            m_cnt[0] = 0; m_cnt[1] = 0;
            m_data = '0; m_keep = '0; m_bcnt = '0;
        end else if (m_stage == FREE) begin
            if (w >= 0) begin
                m_owner = w;
                m_data  = (w == 1) ? data_hdr1 : data_hdr0;
                m_keep  = (w == 1) ? keep_hdr1 : keep_hdr0;
                m_bcnt  = (w == 1) ? byte_cnt_hdr1 : byte_cnt_hdr0;
                m_stage = HDR;
            end
        end else if (m_stage == HDR) begin
            if (ready_insert) m_stage = PKT;
        end else if (mon_valid && mon_ready && mon_last) begin
            m_cnt[m_owner] = (m_cnt[m_owner] + 1) % (1 << NW);
            m_last  = m_owner;
            m_stage = FREE;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_mon(input logic v);
        mon_valid = v; mon_ready = v; mon_last = v;
    endtask

    initial begin
        int beat;
        int guard;
        m_stage = FREE; m_owner = 0; m_last = 1; m_cnt[0] = 0; m_cnt[1] = 0;
        m_data = '0; m_keep = '0; m_bcnt = '0;

        rst = 1'b1; valid_hdr0 = 1'b1; valid_hdr1 = 1'b1;
        data_hdr0 = '0; data_hdr1 = '0; keep_hdr0 = '0; keep_hdr1 = '0;
        byte_cnt_hdr0 = '0; byte_cnt_hdr1 = '0; ready_insert = 1'b0;
        set_mon(1'b0);
        repeat (3) cycle();

        // First tie after reset goes to requester 0.
        rst = 1'b0;
        data_hdr0 = 32'hDEADBEEF; data_hdr1 = 32'hCAFEF00D;
        keep_hdr0 = 4'hF; keep_hdr1 = 4'h3; byte_cnt_hdr0 = 2'd3; byte_cnt_hdr1 = 2'd1;
        #2;
        chk("r037_ready0", 32'(ready_hdr0), 32'd1);
        chk("r037_ready1", 32'(ready_hdr1), 32'd0);
        cycle();
        valid_hdr0 = 1'b0; valid_hdr1 = 1'b0;
        #2;
        chk("r037_valid_insert", 32'(valid_insert), 32'd1);
        chk("r037_data", data_insert, 32'hDEADBEEF);
        chk("r037_grant", 32'(grant_id), 32'd0);

        // Stall in OFFER while requester 1 waits and stray last beats appear.
        data_hdr0 = 32'h12345678; valid_hdr1 = 1'b1;
        set_mon(1'b1);
        repeat (5) cycle();
        chk("r038_data", data_insert, 32'hDEADBEEF);
        chk("r038_keep", 32'(keep_insert), 32'hF);
        chk("r038_bcnt", 32'(byte_insert_cnt), 32'd3);
        chk("r038_valid", 32'(valid_insert), 32'd1);
        chk("r030_cnt0", 32'(pkt_cnt0), 32'd0);
        set_mon(1'b0);
        ready_insert = 1'b1;
        cycle();
        ready_insert = 1'b0;
        #2;
        chk("r026_valid_drop", 32'(valid_insert), 32'd0);
        chk("r026_busy", 32'(busy), 32'd1);
        mon_valid = 1'b1; mon_ready = 1'b1;
        repeat (2) cycle();
        mon_last = 1'b1;
        cycle();
        set_mon(1'b0);
        #2;
        chk("r040_ready1", 32'(ready_hdr1), 32'd1);
        chk("r040_cnt0", 32'(pkt_cnt0), 32'd1);
        cycle();
        valid_hdr1 = 1'b0;
        #2;
        chk("r040_valid_insert", 32'(valid_insert), 32'd1);
        chk("r040_data", data_insert, 32'hCAFEF00D);
        chk("r040_grant", 32'(grant_id), 32'd1);
        ready_insert = 1'b1;
        cycle();
        ready_insert = 1'b0;
        set_mon(1'b1);
        cycle();
        set_mon(1'b0);

        // Four 3-beat packets with both requesters always asking.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        obs_grants.delete();
        valid_hdr0 = 1'b1; valid_hdr1 = 1'b1; ready_insert = 1'b1;
        mon_valid = 1'b1; mon_ready = 1'b1;
        beat = 0; guard = 0;
        while ((m_cnt[0] + m_cnt[1]) < 4 && guard < 200) begin
            if (m_stage == PKT) begin
                mon_last = (beat == 2);
                beat++;
            end else begin
                beat = 0;
                mon_last = 1'($urandom_range(0, 1));
            end
            cycle();
            guard++;
        end
        chk("r039_ngrants", 32'(obs_grants.size()), 32'd4);
        for (int i = 0; i < 4 && i < obs_grants.size(); i++)
            chk("r039_grant_order", 32'(obs_grants[i]), 32'(i % 2));
        #2;
        chk("r039_cnt0", 32'(pkt_cnt0), 32'd2);
        chk("r039_cnt1", 32'(pkt_cnt1), 32'd2);
        valid_hdr0 = 1'b0; valid_hdr1 = 1'b0; ready_insert = 1'b0;
        set_mon(1'b0);

        // Reset lands in WAIT_LAST together with a last beat.
        valid_hdr0 = 1'b1;
        cycle();
        valid_hdr0 = 1'b0; ready_insert = 1'b1;
        cycle();
        ready_insert = 1'b0;
        rst = 1'b1; set_mon(1'b1);
        cycle();
        rst = 1'b0; set_mon(1'b0);
        #2;
        chk("r041_busy", 32'(busy), 32'd0);
        chk("r041_valid", 32'(valid_insert), 32'd0);
        chk("r041_cnt0", 32'(pkt_cnt0), 32'd0);
        chk("r041_cnt1", 32'(pkt_cnt1), 32'd0);

        // Counter wrap on a narrowed counter.
        valid_hdr0 = 1'b1; ready_insert = 1'b1; set_mon(1'b1);
        guard = 0;
        while (m_cnt[0] != (1 << NW) - 1 && guard < 2000) begin
            cycle();
            guard++;
        end
        chk("r042_all_ones", 32'(pkt_cnt0), 32'hFF);
        guard = 0;
        while (m_cnt[0] != 0 && guard < 10) begin
            cycle();
            guard++;
        end
        chk("r042_wrap", 32'(pkt_cnt0), 32'd0);
        valid_hdr0 = 1'b0; ready_insert = 1'b0; set_mon(1'b0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            rst           = ($urandom_range(0, 99) == 0);
            valid_hdr0    = 1'($urandom_range(0, 1));
            valid_hdr1    = 1'($urandom_range(0, 1));
            data_hdr0     = $urandom;
            data_hdr1     = $urandom;
            keep_hdr0     = 4'($urandom);
            keep_hdr1     = 4'($urandom);
            byte_cnt_hdr0 = 2'($urandom);
            byte_cnt_hdr1 = 2'($urandom);
            ready_insert  = 1'($urandom_range(0, 1));
            mon_valid     = ($urandom_range(0, 3) != 0);
            mon_ready     = ($urandom_range(0, 3) != 0);
            mon_last      = ($urandom_range(0, 2) == 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_stream_header_arbiter.md
AXI_STREAM_HEADER_ARBITER -- requirements
Module: axi_stream_header_arbiter

Interface
REQ-001 Parameter DATA_WD, default 32, stream and header data width in bits.
REQ-002 Parameter DATA_BYTE_WD, default DATA_WD/8, keep width in bytes.
REQ-003 Parameter BYTE_CNT_WD, default $clog2(DATA_BYTE_WD), header byte-count width.
REQ-004 Parameter CNT_WD, default 16, per-requester packet counter width.
REQ-005 Clocking SHALL be one clock and a synchronous active-high reset.
REQ-006 clk  input  1  sole clock; all state updates on rising edge.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 valid_hdr0 / valid_hdr1  input  1 each  header request from requester 0 / 1.
REQ-009 data_hdr0 / data_hdr1  input  DATA_WD each  header data.
REQ-010 keep_hdr0 / keep_hdr1  input  DATA_BYTE_WD each  header keep.
REQ-011 byte_cnt_hdr0 / byte_cnt_hdr1  input  BYTE_CNT_WD each  header byte count.
REQ-012 ready_hdr0 / ready_hdr1  output  1 each  header accepted this cycle.
REQ-013 valid_insert  output  1  header offered to inserter.
REQ-014 data_insert  output  DATA_WD  registered header data.
REQ-015 keep_insert  output  DATA_BYTE_WD  registered header keep.
REQ-016 byte_insert_cnt  output  BYTE_CNT_WD  registered header byte count.
REQ-017 ready_insert  input  1  inserter accepts header.
REQ-018 mon_valid, mon_ready, mon_last  input  1 each  copy of inserter output valid_out/ready_out/last_out.
REQ-019 grant_id  output  1  requester owning the current packet.
REQ-020 busy  output  1  high whenever state is not IDLE.
REQ-021 pkt_cnt0 / pkt_cnt1  output  CNT_WD each  completed packets per requester.

Function
REQ-022 FSM SHALL have states IDLE, OFFER, WAIT_LAST (registered).
REQ-023 IDLE: any valid_hdrN high -> select winner, assert ready_hdrN combinationally for winner only, capture its data/keep/byte_cnt into output registers, set grant_id, go OFFER.
REQ-024 Arbitration SHALL be round-robin: one requester valid -> it wins; both valid -> requester != last_grant wins.
REQ-025 ready_hdr0/1 SHALL be 0 outside IDLE and never both high.
REQ-026 OFFER: valid_insert=1 with data_insert/keep_insert/byte_insert_cnt stable until ready_insert; on valid_insert&ready_insert go WAIT_LAST, valid_insert=0 next cycle.
REQ-027 Latency: header accepted at cycle T -> valid_insert high at T+1; ready_insert high at T+1 -> WAIT_LAST at T+2.
REQ-028 WAIT_LAST: mon_valid&mon_ready&mon_last -> go IDLE, last_grant<=grant_id, pkt_cnt[grant_id] +1.
REQ-029 pkt_cntN SHALL wrap modulo 2^CNT_WD without saturation or flag.
REQ-030 mon_* SHALL be ignored in IDLE and OFFER; no counter change.
REQ-031 Request arriving during OFFER/WAIT_LAST SHALL wait; earliest acceptance is first IDLE cycle (last beat at L -> ready_hdrN at L+1 -> valid_insert at L+2).
REQ-032 Header registers SHALL hold last value in IDLE/WAIT_LAST; only valid_insert qualifies them.
REQ-033 valid_hdrN dropping without ready_hdrN SHALL cause no state change.

Reset
REQ-034 rst high at a clock edge SHALL force IDLE from any state, aborting any offered or in-flight packet.
REQ-035 Reset values: valid_insert 0, data_insert 0, keep_insert 0, byte_insert_cnt 0, grant_id 0, busy 0, pkt_cnt0/1 0, last_grant 1 (requester 0 wins first tie).
REQ-036 ready_hdr0/1 SHALL be 0 during any cycle with rst high.

Verification
REQ-037 After reset, both valid, data_hdr0=DEADBEEF, data_hdr1=CAFEF00D -> ready_hdr0 pulse, next cycle valid_insert=1, data_insert=DEADBEEF, grant_id=0.
REQ-038 ready_insert held low 5 cycles in OFFER -> data_insert/keep_insert/byte_insert_cnt unchanged, valid_insert stays 1, ready_hdr0/1 stay 0.
REQ-039 Both requesters continuously valid, 4 packets of 3 beats each -> grants 0,1,0,1; pkt_cnt0=2, pkt_cnt1=2.
REQ-040 mon_last beat at cycle L with requester 1 waiting -> ready_hdr1 at L+1, valid_insert at L+2; mon_last pulses in OFFER ignored.
REQ-041 rst asserted in WAIT_LAST -> next cycle busy=0, valid_insert=0, pkt_cnt unchanged by pending last, counters 0.
REQ-042 Preload pkt_cnt0 to 16'hFFFF via 65535 packets (or forced), one more packet -> pkt_cnt0=0.
